// File: rtl/alarm_ctrl.sv
// alarm_ctrl -- alarm clock controller driven by a 1 Hz clock.
//
// Compares the timekeeper's hour/min/sec against a stored alarm time and
// steps through DISARMED / ARMED / RINGING / SNOOZING. A single shared
// countdown times both the ring period and the snooze period.
//
// Optional feature: define ALARM_CHIME_EN to enable the hourly chime pulse.
// Without it, chime is tied low and no chime logic is built.
//
// Ports
//   clk            1 Hz system clock, rising edge
//   reset          asynchronous reset, active low
//   hour/min/sec   current time from the timekeeper
//   arm            level, 1 = alarm enabled
//   set_alarm      one-cycle strobe loading alarm_hour_in/alarm_min_in
//   alarm_hour_in  requested alarm hour (0-23)
//   alarm_min_in   requested alarm minute (0-59)
//   snooze, stop   user requests, sampled every cycle
//   buzzer         registered, high while state is RINGING
//   state          00 DISARMED, 01 ARMED, 10 RINGING, 11 SNOOZING
//   snooze_cnt     snoozes used in the current alarm event
//   set_err        one-cycle pulse on a rejected set_alarm
//   alarm_hour/min stored alarm time
//   chime          one-cycle hourly pulse (ALARM_CHIME_EN only)
module alarm_ctrl #(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] hour,
  input  logic [5:0] min,
  input  logic [5:0] sec,
  input  logic       arm,
  input  logic       set_alarm,
  input  logic [4:0] alarm_hour_in,
  input  logic [5:0] alarm_min_in,
  input  logic       snooze,
  input  logic       stop,
  output logic       buzzer,
  output logic [1:0] state,
  output logic [1:0] snooze_cnt,
  output logic       set_err,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min,
  output logic       chime
);

  typedef enum logic [1:0] {
    DISARMED = 2'b00,
    ARMED    = 2'b01,
    RINGING  = 2'b10,
    SNOOZING = 2'b11
  } state_t;

  localparam int MAX_T = (RING_SEC > SNOOZE_SEC) ? RING_SEC : SNOOZE_SEC;
  localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

  localparam logic [CW-1:0] RING_LD  = CW'(RING_SEC - 1);
  localparam logic [CW-1:0] SNZ_LD   = CW'(SNOOZE_SEC - 1);
  localparam logic [CW-1:0] CTR_ONE  = CW'(1);
  localparam logic [1:0]    MAX_SNZ  = 2'(MAX_SNOOZE);

  state_t        state_q, state_d;
  logic [CW-1:0] ctr_q, ctr_d;
  logic [1:0]    snz_q, snz_d;
  logic          fired_q, fired_d;
  logic [4:0]    ahour_q;
  logic [5:0]    amin_q;
  logic          buzzer_q, set_err_q;

  logic set_ok, set_bad, match;

  assign set_ok  = set_alarm & (alarm_hour_in <= 5'd23) & (alarm_min_in <= 6'd59);
  assign set_bad = set_alarm & ~set_ok;
  assign match   = arm & (hour == ahour_q) & (min == amin_q) & (sec == 6'd0) & ~fired_q;

  // fired blocks a second trigger inside the alarm minute; a new valid
  // alarm time re-opens the trigger immediately.
  always_comb begin
    fired_d = fired_q;
    if (set_ok)
      fired_d = 1'b0;
    else if (match)
      fired_d = 1'b1;
    else if (min != amin_q)
      fired_d = 1'b0;
  end

  // Priority: arm=0 > set_alarm (valid or rejected) > stop > snooze > timeout.
  // A rejected set_alarm holds state and countdown for that cycle.
  always_comb begin
    state_d = state_q;
    ctr_d   = ctr_q;
    snz_d   = snz_q;
    if (!arm) begin
      state_d = DISARMED;
      ctr_d   = '0;
      snz_d   = 2'd0;
    end else if (set_ok) begin
      state_d = ARMED;
      ctr_d   = '0;
      snz_d   = 2'd0;
    end else if (!set_bad) begin
      unique case (state_q)
        DISARMED: state_d = ARMED;
        ARMED: begin
          if (match) begin
            state_d = RINGING;
            ctr_d   = RING_LD;
          end
        end
        RINGING: begin
          if (stop) begin
            state_d = ARMED;
            ctr_d   = '0;
            snz_d   = 2'd0;
          end else if (snooze && (snz_q < MAX_SNZ)) begin
            state_d = SNOOZING;
            ctr_d   = SNZ_LD;
            snz_d   = snz_q + 2'd1;
          end else if (ctr_q == '0) begin
            state_d = ARMED;
            snz_d   = 2'd0;
          end else begin
            ctr_d = ctr_q - CTR_ONE;
          end
        end
        SNOOZING: begin
          if (stop) begin
            state_d = ARMED;
            ctr_d   = '0;
            snz_d   = 2'd0;
          end else if (ctr_q == '0) begin
            state_d = RINGING;
            ctr_d   = RING_LD;
          end else begin
            ctr_d = ctr_q - CTR_ONE;
          end
        end
        default: state_d = DISARMED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= DISARMED;
      ctr_q     <= '0;
      snz_q     <= 2'd0;
      fired_q   <= 1'b0;
      ahour_q   <= 5'd0;
      amin_q    <= 6'd0;
      buzzer_q  <= 1'b0;
      set_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctr_q     <= ctr_d;
      snz_q     <= snz_d;
      fired_q   <= fired_d;
      buzzer_q  <= (state_d == RINGING);
      set_err_q <= set_bad;
      if (set_ok) begin
        ahour_q <= alarm_hour_in;
        amin_q  <= alarm_min_in;
      end
    end
  end

`ifdef ALARM_CHIME_EN
  logic chime_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      chime_q <= 1'b0;
    else
      chime_q <= (min == 6'd0) && (sec == 6'd0);
  end

  assign chime = chime_q;
`else
  assign chime = 1'b0;
`endif

  assign state      = state_q;
  assign buzzer     = buzzer_q;
  assign snooze_cnt = snz_q;
  assign set_err    = set_err_q;
  assign alarm_hour = ahour_q;
  assign alarm_min  = amin_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
`timescale 1ns/1ps
module tb_alarm_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] hr;
  logic [5:0] mn;
  logic [5:0] sc;
  logic       arm, set_alarm, snooze, stop;
  logic [4:0] alarm_hour_in;
  logic [5:0] alarm_min_in;
  logic       buzzer, set_err, chime;
  logic [1:0] state, snooze_cnt;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;

  int checks = 0;
  int errors = 0;

  alarm_ctrl dut (
    .clk(clk), .reset(reset), .hour(hr), .min(mn), .sec(sc),
    .arm(arm), .set_alarm(set_alarm), .alarm_hour_in(alarm_hour_in),
    .alarm_min_in(alarm_min_in), .snooze(snooze), .stop(stop),
    .buzzer(buzzer), .state(state), .snooze_cnt(snooze_cnt),
    .set_err(set_err), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
    .chime(chime)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock edge, then the timekeeper advances one second.
  task automatic tick();
    @(posedge clk);
    #1;
    if (sc == 6'd59) begin
      sc = 6'd0;
      if (mn == 6'd59) begin
        mn = 6'd0;
        hr = (hr == 5'd23) ? 5'd0 : hr + 5'd1;
      end else begin
        mn = mn + 6'd1;
      end
    end else begin
      sc = sc + 6'd1;
    end
  endtask

  task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    hr = h; mn = m; sc = s;
  endtask

  // From 07:29:59 two edges reach the 07:30:00 match.
  task automatic ring_0730(input string tag);
    set_time(5'd7, 6'd29, 6'd59);
    tick();
    tick();
    check(tag, state, 32'd2);
  endtask

  task automatic load_alarm(input logic [4:0] h, input logic [5:0] m);
    set_alarm = 1'b1; alarm_hour_in = h; alarm_min_in = m;
    tick();
    set_alarm = 1'b0;
  endtask

  int n;
  logic any_buzz;

  initial begin
    reset = 1'b0; arm = 1'b0; set_alarm = 1'b0; snooze = 1'b0; stop = 1'b0;
    alarm_hour_in = '0; alarm_min_in = '0;
    set_time(5'd0, 6'd0, 6'd1);
    #12;
    check("rst_state", state, 32'd0);
    check("rst_buzzer", buzzer, 32'd0);
    check("rst_snz", snooze_cnt, 32'd0);
    check("rst_seterr", set_err, 32'd0);
    check("rst_chime", chime, 32'd0);
    check("rst_ahour", alarm_hour, 32'd0);
    check("rst_amin", alarm_min, 32'd0);

    tick();
    reset = 1'b1;
    tick();
    check("disarmed_hold", state, 32'd0);

    arm = 1'b1;
    load_alarm(5'd7, 6'd30);
    check("set_ahour", alarm_hour, 32'd7);
    check("set_amin", alarm_min, 32'd30);
    check("armed", state, 32'd1);

    set_time(5'd7, 6'd29, 6'd58);
    tick();
    check("pre_match", state, 32'd1);
    tick();
    check("at_0729_59", state, 32'd1);
    check("no_buzz_yet", buzzer, 32'd0);
    tick();
    check("ring_state", state, 32'd2);
    check("ring_buzzer", buzzer, 32'd1);

    n = 1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (buzzer) n++;
      else break;
    end
    check("ring_len", n, 32'd60);
    check("after_ring_state", state, 32'd1);
    check("after_ring_snz", snooze_cnt, 32'd0);
    any_buzz = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      any_buzz = any_buzz | buzzer;
    end
    check("no_rering", any_buzz, 32'd0);

    ring_0730("snz_ring_start");
    for (int k = 1; k <= 3; k++) begin
      snooze = 1'b1;
      tick();
      snooze = 1'b0;
      check("snz_state", state, 32'd3);
      check("snz_cnt", snooze_cnt, k);
      n = 1;
      for (int i = 0; i < 400; i++) begin
        tick();
        if (state == 2'd3) n++;
        else break;
      end
      check("snz_gap", n, 32'd300);
      check("rering", state, 32'd2);
    end
    snooze = 1'b1;
    tick();
    snooze = 1'b0;
    check("snz4_ignored", state, 32'd2);
    check("snz4_cnt", snooze_cnt, 32'd3);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_state", state, 32'd1);
    check("stop_cnt", snooze_cnt, 32'd0);

    load_alarm(5'd24, 6'd10);
    check("bad_set_err", set_err, 32'd1);
    check("bad_set_ahour", alarm_hour, 32'd7);
    check("bad_set_amin", alarm_min, 32'd30);
    check("bad_set_state", state, 32'd1);
    tick();
    check("set_err_1cyc", set_err, 32'd0);

    ring_0730("both_ring_start");
    stop = 1'b1; snooze = 1'b1;
    tick();
    stop = 1'b0; snooze = 1'b0;
    check("stop_wins", state, 32'd1);
    check("stop_wins_cnt", snooze_cnt, 32'd0);

    ring_0730("set_ring_start");
    load_alarm(5'd7, 6'd30);
    check("set_in_ring", state, 32'd1);
    check("set_in_ring_buz", buzzer, 32'd0);

    arm = 1'b0;
    tick();
    check("disarm", state, 32'd0);
    arm = 1'b1;
    tick();
    check("rearm", state, 32'd1);

    ring_0730("rst_ring_start");
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("async_state", state, 32'd0);
    check("async_buzzer", buzzer, 32'd0);
    check("async_ahour", alarm_hour, 32'd0);
    check("async_amin", alarm_min, 32'd0);
    tick();
    reset = 1'b1;
    arm = 1'b0;

    set_time(5'd9, 6'd59, 6'd59);
    tick();
    check("chime_pre", chime, 32'd0);
    tick();
`ifdef ALARM_CHIME_EN
    check("chime_pulse", chime, 32'd1);
`else
    check("chime_off", chime, 32'd0);
`endif
    tick();
    check("chime_end", chime, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_ctrl.md
ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameter RING_SEC, default 60: clock cycles (seconds) RINGING lasts before auto-stop.
REQ-002 Parameter SNOOZE_SEC, default 300: clock cycles spent in SNOOZING before re-ring.
REQ-003 Parameter MAX_SNOOZE, default 3: snoozes allowed per alarm event; range 0..3.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-005 Port: clk  in  1  1 Hz system clock, rising-edge; the same clock as the timekeeper.
REQ-006 Port: reset  in  1  asynchronous, active-low.
REQ-007 Port: hour  in  5  current hour, 0-23, from the timekeeper.
REQ-008 Port: min  in  6  current minute, 0-59.
REQ-009 Port: sec  in  6  current second, 0-59.
REQ-010 Port: arm  in  1  level; 1 = alarm enabled.
REQ-011 Port: set_alarm  in  1  one-cycle strobe; loads alarm_hour_in/alarm_min_in.
REQ-012 Port: alarm_hour_in  in  5  requested alarm hour.
REQ-013 Port: alarm_min_in  in  6  requested alarm minute.
REQ-014 Port: snooze  in  1  sampled each cycle; 1 = snooze request.
REQ-015 Port: stop  in  1  sampled each cycle; 1 = stop request.
REQ-016 Port: buzzer  out  1  registered; 1 while state is RINGING.
REQ-017 Port: state  out  2  00 DISARMED, 01 ARMED, 10 RINGING, 11 SNOOZING.
REQ-018 Port: snooze_cnt  out  2  snoozes used in the current alarm event.
REQ-019 Port: set_err  out  1  one-cycle pulse on a rejected set_alarm.
REQ-020 Port: alarm_hour  out  5  stored alarm hour.
REQ-021 Port: alarm_min  out  6  stored alarm minute.
REQ-022 Port: chime  out  1  hourly chime pulse (see Configuration).

Function
REQ-023 match = arm & (hour==alarm_hour) & (min==alarm_min) & (sec==0) & ~fired; fired sets on match and clears when min!=alarm_min.
REQ-024 ARMED + match -> RINGING at that edge; buzzer=1 from the next cycle; countdown ring_ctr loads RING_SEC-1.
REQ-025 RINGING: decrement each cycle; at 0 with no request -> ARMED, snooze_cnt=0.
REQ-026 RINGING + snooze, snooze_cnt<MAX_SNOOZE -> SNOOZING, snooze_cnt+1, countdown loads SNOOZE_SEC-1; snooze_cnt==MAX_SNOOZE -> snooze ignored.
REQ-027 SNOOZING: at countdown 0 -> RINGING, reload RING_SEC-1; match is ignored while SNOOZING.
REQ-028 stop in RINGING or SNOOZING -> ARMED, snooze_cnt=0; stop and snooze together: stop wins.
REQ-029 arm=0 in any state -> DISARMED at the next edge, snooze_cnt=0; arm 0->1 -> ARMED; priority arm=0 > set_alarm > stop > snooze > timeout.
REQ-030 set_alarm with alarm_hour_in<=23 and alarm_min_in<=59: registers update next edge, fired cleared; if RINGING/SNOOZING -> ARMED, snooze_cnt=0.
REQ-031 set_alarm with out-of-range values: stored alarm unchanged, state unchanged, set_err=1 for exactly one cycle.
REQ-032 Countdowns wide enough for max(RING_SEC,SNOOZE_SEC)-1; no wrap below 0.

Reset
REQ-033 reset low asynchronously forces state=DISARMED, buzzer=0, snooze_cnt=0, set_err=0, chime=0, alarm_hour=0, alarm_min=0, fired=0, counters=0.
REQ-034 Reset release is synchronous to clk; the first evaluation of match occurs on the first rising edge with reset high.

Configuration
REQ-035 Macro ALARM_CHIME_EN defined: chime=1 for one cycle, registered, on the cycle after inputs show min==0 and sec==0, independent of arm/state.
REQ-036 Macro ALARM_CHIME_EN undefined: chime tied to 0, no chime logic; all other behaviour identical.

Verification
REQ-037 set 07:30, arm=1, time 07:29:59 -> 07:30:00 -> state RINGING, buzzer=1 on the following cycle.
REQ-038 ringing with no input -> buzzer high exactly 60 cycles, then state ARMED, snooze_cnt=0; no re-ring during 07:30:01-07:30:59.
REQ-039 snooze pressed 4 times across re-rings -> 3 accepted (300-cycle gaps), snooze_cnt=3, 4th ignored; stop -> ARMED, snooze_cnt=0.
REQ-040 set_alarm with 24:10 -> set_err pulses 1 cycle, alarm_hour/alarm_min keep 07:30; stop+snooze same cycle while RINGING -> ARMED.
REQ-041 reset low mid-RINGING -> immediate DISARMED, buzzer=0, alarm 00:00; with ALARM_CHIME_EN, 09:59:59 -> 10:00:00 -> chime 1 cycle.
